// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant locked for the
// owner's whole cyc, combinational pass-through, and a stalled-stb watchdog.
module wb_arbiter_2to1 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s0_cyc,
    input  logic                    s0_stb,
    input  logic                    s0_we,
    input  logic [ADDR_WIDTH-1:0]   s0_adr,
    input  logic [DATA_WIDTH/8-1:0] s0_sel,
    input  logic [DATA_WIDTH-1:0]   s0_dat_mosi,
    output logic                    s0_ack,
    output logic                    s0_err,
    output logic [DATA_WIDTH-1:0]   s0_dat_miso,
    input  logic                    s1_cyc,
    input  logic                    s1_stb,
    input  logic                    s1_we,
    input  logic [ADDR_WIDTH-1:0]   s1_adr,
    input  logic [DATA_WIDTH/8-1:0] s1_sel,
    input  logic [DATA_WIDTH-1:0]   s1_dat_mosi,
    output logic                    s1_ack,
    output logic                    s1_err,
    output logic [DATA_WIDTH-1:0]   s1_dat_miso,
    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [ADDR_WIDTH-1:0]   m_adr,
    output logic [DATA_WIDTH/8-1:0] m_sel,
    output logic [DATA_WIDTH-1:0]   m_dat_mosi,
    input  logic                    m_ack,
    input  logic                    m_err,
    input  logic [DATA_WIDTH-1:0]   m_dat_miso
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic                 WD_EN    = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    logic [1:0]           state_r;
    logic                 last_r;
    logic [CNT_WIDTH-1:0] wd_cnt_r;

    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  sel_cyc_s;
    logic                  sel_stb_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_adr_s;
    logic [SEL_WIDTH-1:0]  sel_sel_s;
    logic [DATA_WIDTH-1:0] sel_dat_s;
    logic                  stall_s;
    logic                  timeout_s;

    assign gnt0_s = (state_r == ST_GNT0);
    assign gnt1_s = (state_r == ST_GNT1);

    // Select the owning master's request signals; nothing is driven in IDLE.
    always_comb begin
        sel_cyc_s = 1'b0;
        sel_stb_s = 1'b0;
        sel_we_s  = 1'b0;
        sel_adr_s = '0;
        sel_sel_s = '0;
        sel_dat_s = '0;
        if (gnt0_s) begin
            sel_cyc_s = s0_cyc;
            sel_stb_s = s0_stb;
            sel_we_s  = s0_we;
            sel_adr_s = s0_adr;
            sel_sel_s = s0_sel;
            sel_dat_s = s0_dat_mosi;
        end else if (gnt1_s) begin
            sel_cyc_s = s1_cyc;
            sel_stb_s = s1_stb;
            sel_we_s  = s1_we;
            sel_adr_s = s1_adr;
            sel_sel_s = s1_sel;
            sel_dat_s = s1_dat_mosi;
        end else begin
            sel_cyc_s = 1'b0;
        end
    end

    // The abort fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
    assign stall_s   = sel_stb_s & ~m_ack & ~m_err;
    assign timeout_s = WD_EN & stall_s & (wd_cnt_r == CNT_LAST);

    // Pass-through to the slave; cyc/stb are withdrawn in the abort cycle.
    always_comb begin
        m_cyc       = sel_cyc_s & ~timeout_s;
        m_stb       = sel_stb_s & ~timeout_s;
        m_we        = sel_we_s;
        m_adr       = sel_adr_s;
        m_sel       = sel_sel_s;
        m_dat_mosi  = sel_dat_s;
        s0_ack      = gnt0_s & m_ack & ~m_err;
        s0_err      = gnt0_s & (m_err | timeout_s);
        s0_dat_miso = {DATA_WIDTH{gnt0_s}} & m_dat_miso;
        s1_ack      = gnt1_s & m_ack & ~m_err;
        s1_err      = gnt1_s & (m_err | timeout_s);
        s1_dat_miso = {DATA_WIDTH{gnt1_s}} & m_dat_miso;
    end

    // Arbitration state, round-robin history and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            last_r   <= 1'b1;
            wd_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wd_cnt_r <= '0;
                    if (s0_cyc && s1_cyc) begin
                        state_r <= last_r ? ST_GNT0 : ST_GNT1;
                    end else if (s0_cyc) begin
                        state_r <= ST_GNT0;
                    end else if (s1_cyc) begin
                        state_r <= ST_GNT1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (!sel_cyc_s || timeout_s) begin
                        state_r  <= ST_IDLE;
                        last_r   <= gnt1_s;
                        wd_cnt_r <= '0;
                    end else if (stall_s && WD_EN) begin
                        wd_cnt_r <= wd_cnt_r + CNT_WIDTH'(1);
                    end else begin
                        wd_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wd_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Randomized bench for wb_arbiter_2to1: random masters, random slave responses
// and random resets, every output checked each cycle against an ownership model.
module tb_wb_arbiter_2to1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_cyc, s0_stb, s0_we;
    logic [AW-1:0] s0_adr;
    logic [SW-1:0] s0_sel;
    logic [DW-1:0] s0_dat_mosi;
    logic          s0_ack, s0_err;
    logic [DW-1:0] s0_dat_miso;
    logic          s1_cyc, s1_stb, s1_we;
    logic [AW-1:0] s1_adr;
    logic [SW-1:0] s1_sel;
    logic [DW-1:0] s1_dat_mosi;
    logic          s1_ack, s1_err;
    logic [DW-1:0] s1_dat_miso;
    logic          m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_dat_mosi;
    logic          m_ack, m_err;
    logic [DW-1:0] m_dat_miso;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus, who owned it last, stalled cycles so far.
    int owner;
    int last_owner;
    int stalls;

    wb_arbiter_2to1 #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_cyc     (s0_cyc),
        .s0_stb     (s0_stb),
        .s0_we      (s0_we),
        .s0_adr     (s0_adr),
        .s0_sel     (s0_sel),
        .s0_dat_mosi(s0_dat_mosi),
        .s0_ack     (s0_ack),
        .s0_err     (s0_err),
        .s0_dat_miso(s0_dat_miso),
        .s1_cyc     (s1_cyc),
        .s1_stb     (s1_stb),
        .s1_we      (s1_we),
        .s1_adr     (s1_adr),
        .s1_sel     (s1_sel),
        .s1_dat_mosi(s1_dat_mosi),
        .s1_ack     (s1_ack),
        .s1_err     (s1_err),
        .s1_dat_miso(s1_dat_miso),
        .m_cyc      (m_cyc),
        .m_stb      (m_stb),
        .m_we       (m_we),
        .m_adr      (m_adr),
        .m_sel      (m_sel),
        .m_dat_mosi (m_dat_mosi),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .m_dat_miso (m_dat_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic o_cyc, o_stb;
        if (rst) begin
            owner = -1;
            last_owner = 1;
            stalls = 0;
        end else if (owner < 0) begin
            stalls = 0;
            if (s0_cyc && s1_cyc) owner = (last_owner == 0) ? 1 : 0;
            else if (s0_cyc)      owner = 0;
            else if (s1_cyc)      owner = 1;
        end else begin
            o_cyc = (owner == 1) ? s1_cyc : s0_cyc;
            o_stb = (owner == 1) ? s1_stb : s0_stb;
            if (!o_cyc) begin
                last_owner = owner;
                owner = -1;
                stalls = 0;
            end else if (o_stb && !m_ack && !m_err) begin
                stalls++;
                if (stalls == TO) begin
                    last_owner = owner;
                    owner = -1;
                    stalls = 0;
                end
            end else begin
                stalls = 0;
            end
        end
    endtask

    // Randomize both masters, the slave response and occasional reset.
    task automatic drive(input int cyc_no);
        int r;
        rst = (cyc_no < 3) || ($urandom_range(0, 149) == 0);
        if (s0_cyc) s0_cyc = ($urandom_range(0, 7) != 0);
        else        s0_cyc = ($urandom_range(0, 3) == 0);
        if (s1_cyc) s1_cyc = ($urandom_range(0, 7) != 0);
        else        s1_cyc = ($urandom_range(0, 3) == 0);
        s0_stb      = s0_cyc && ($urandom_range(0, 3) != 0);
        s1_stb      = s1_cyc && ($urandom_range(0, 3) != 0);
        s0_we       = 1'($urandom_range(0, 1));
        s1_we       = 1'($urandom_range(0, 1));
        s0_adr      = $urandom();
        s1_adr      = $urandom();
        s0_sel      = 4'($urandom_range(0, 15));
        s1_sel      = 4'($urandom_range(0, 15));
        s0_dat_mosi = $urandom();
        s1_dat_mosi = $urandom();
        r = $urandom_range(0, 31);
        m_ack       = (r < 8) || (r == 9);
        m_err       = (r == 8) || (r == 9);
        m_dat_miso  = $urandom();
    endtask

    // Compare every DUT output with what the ownership model predicts.
    task automatic check_outputs();
        logic          e_cyc, e_stb, e_we, tmo, stalled;
        logic [AW-1:0] e_adr;
        logic [SW-1:0] e_sel;
        logic [DW-1:0] e_dat;
        logic          a_ack, a_err;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_sel = '0; e_dat = '0;
        tmo = 1'b0;
        if (owner >= 0) begin
            e_cyc = (owner == 1) ? s1_cyc : s0_cyc;
            e_stb = (owner == 1) ? s1_stb : s0_stb;
            e_we  = (owner == 1) ? s1_we : s0_we;
            e_adr = (owner == 1) ? s1_adr : s0_adr;
            e_sel = (owner == 1) ? s1_sel : s0_sel;
            e_dat = (owner == 1) ? s1_dat_mosi : s0_dat_mosi;
            stalled = e_stb && !m_ack && !m_err;
            tmo = stalled && (stalls + 1 == TO);
            if (tmo) begin
                e_cyc = 1'b0;
                e_stb = 1'b0;
            end
        end
        a_ack = !m_err && m_ack;
        a_err = m_err || tmo;
        check("m_cyc", 64'(m_cyc), 64'(e_cyc));
        check("m_stb", 64'(m_stb), 64'(e_stb));
        check("m_we", 64'(m_we), 64'(e_we));
        check("m_adr", 64'(m_adr), 64'(e_adr));
        check("m_sel", 64'(m_sel), 64'(e_sel));
        check("m_dat_mosi", 64'(m_dat_mosi), 64'(e_dat));
        check("s0_ack", 64'(s0_ack), 64'((owner == 0) && a_ack));
        check("s0_err", 64'(s0_err), 64'((owner == 0) && a_err));
        check("s0_dat_miso", 64'(s0_dat_miso), 64'((owner == 0) ? m_dat_miso : 32'h0));
        check("s1_ack", 64'(s1_ack), 64'((owner == 1) && a_ack));
        check("s1_err", 64'(s1_err), 64'((owner == 1) && a_err));
        check("s1_dat_miso", 64'(s1_dat_miso), 64'((owner == 1) ? m_dat_miso : 32'h0));
    endtask

    initial begin
        rst = 1'b1;
        s0_cyc = 1'b0; s0_stb = 1'b0; s0_we = 1'b0;
        s0_adr = '0; s0_sel = '0; s0_dat_mosi = '0;
        s1_cyc = 1'b0; s1_stb = 1'b0; s1_we = 1'b0;
        s1_adr = '0; s1_sel = '0; s1_dat_mosi = '0;
        m_ack = 1'b0; m_err = 1'b0; m_dat_miso = '0;
        owner = -1;
        last_owner = 1;
        stalls = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            model_step();
            #1;
            drive(c);
            @(negedge clk);
            check_outputs();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
